// File: rtl/ps2_line_filter_multi_if.sv
// Bundle of line-filter signals between the pad side (master) and the filter (slave).
// FILTER_GLITCH_CNT_EN adds the glitch counter clear/readback signals.
interface ps2_line_filter_multi_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0]   din;
  logic [CHANNELS-1:0]   dout;
  logic [CHANNELS-1:0]   rise;
  logic [CHANNELS-1:0]   fall;
`ifdef FILTER_GLITCH_CNT_EN
  logic                  glitch_clr;
  logic [8*CHANNELS-1:0] glitch_cnt;

  modport master (output din, glitch_clr, input dout, rise, fall, glitch_cnt);
  modport slave  (input din, glitch_clr, output dout, rise, fall, glitch_cnt);
`else
  modport master (output din, input dout, rise, fall);
  modport slave  (input din, output dout, rise, fall);
`endif
endinterface

// File: rtl/ps2_line_filter_multi.sv
// Multi-channel PS/2 line filter: 2-FF sync, shared sample prescaler, per-lane
// saturating run-length filter with rise/fall strobes. Optional FILTER_GLITCH_CNT_EN.
module ps2_line_filter_lane #(
  parameter int   DEPTH      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       din,
`ifdef FILTER_GLITCH_CNT_EN
  input  logic       glitch_clr,
  output logic [7:0] glitch_cnt,
`endif
  output logic       dout,
  output logic       rise,
  output logic       fall
);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= IDLE_LEVEL;
      s2   <= IDLE_LEVEL;
      dout <= IDLE_LEVEL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        if (s2 == dout) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          // run long enough: accept the new level and strobe its direction
          dout <= s2;
          cnt  <= '0;
          rise <= s2;
          fall <= ~s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef FILTER_GLITCH_CNT_EN
  logic glitch_evt;
  assign glitch_evt = tick && (s2 == dout) && (cnt != '0);

  // clear dominates a same-cycle glitch event
  always_ff @(posedge clk) begin
    if (rst || glitch_clr)
      glitch_cnt <= '0;
    else if (glitch_evt && (glitch_cnt != 8'hFF))
      glitch_cnt <= glitch_cnt + 8'd1;
  end
`endif
endmodule

module ps2_line_filter_multi #(
  parameter int   CHANNELS   = 2,
  parameter int   DEPTH      = 8,
  parameter int   PRESCALE   = 1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  ps2_line_filter_multi_if.slave  bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;
  logic          tick;

  // with PRESCALE=1 pcnt is pinned at 0 and tick stays high
  assign tick = (pcnt == PCNT_MAX);

  always_ff @(posedge clk) begin
    if (rst || tick) pcnt <= '0;
    else             pcnt <= pcnt + 1'b1;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    ps2_line_filter_lane #(
      .DEPTH      (DEPTH),
      .IDLE_LEVEL (IDLE_LEVEL)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .din        (bus.din[i]),
`ifdef FILTER_GLITCH_CNT_EN
      .glitch_clr (bus.glitch_clr),
      .glitch_cnt (bus.glitch_cnt[8*i +: 8]),
`endif
      .dout       (bus.dout[i]),
      .rise       (bus.rise[i]),
      .fall       (bus.fall[i])
    );
  end
endmodule

// File: tb/tb_ps2_line_filter_multi.sv
// Directed + random bench for ps2_line_filter_multi: two DUTs (PRESCALE 1 and 3)
// share the same lines and are checked every cycle against a run-length model.
module tb_ps2_line_filter_multi;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] din = 2'b11;
  logic       clr = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_line_filter_multi_if #(.CHANNELS(2)) bus1 ();
  ps2_line_filter_multi_if #(.CHANNELS(2)) bus3 ();

  assign bus1.din = din;
  assign bus3.din = din;
`ifdef FILTER_GLITCH_CNT_EN
  assign bus1.glitch_clr = clr;
  assign bus3.glitch_clr = clr;
`endif

  ps2_line_filter_multi #(.CHANNELS(2), .DEPTH(DEPTH), .PRESCALE(1), .IDLE_LEVEL(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  ps2_line_filter_multi #(.CHANNELS(2), .DEPTH(DEPTH), .PRESCALE(3), .IDLE_LEVEL(1'b1))
    dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  // reference: delayed samples, consecutive-differing-sample run length per channel
  logic [1:0] m_out[2], m_d1[2], m_d2[2], m_rise[2], m_fall[2];
  int         m_run[2][2];
  int         m_gl[2][2];
  int         m_edges[2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [1:0] d, input logic c);
    for (int u = 0; u < 2; u++) begin
      int ps = (u == 0) ? 1 : 3;
      if (r) begin
        m_out[u] = 2'b11; m_d1[u] = 2'b11; m_d2[u] = 2'b11;
        m_rise[u] = 2'b00; m_fall[u] = 2'b00; m_edges[u] = 0;
        for (int ch = 0; ch < 2; ch++) begin m_run[u][ch] = 0; m_gl[u][ch] = 0; end
      end else begin
        m_edges[u]++;
        m_rise[u] = 2'b00; m_fall[u] = 2'b00;
        if (m_edges[u] % ps == 0) begin
          for (int ch = 0; ch < 2; ch++) begin
            if (m_d2[u][ch] != m_out[u][ch]) begin
              m_run[u][ch]++;
              if (m_run[u][ch] == DEPTH) begin
                m_out[u][ch] = m_d2[u][ch];
                if (m_d2[u][ch]) m_rise[u][ch] = 1'b1; else m_fall[u][ch] = 1'b1;
                m_run[u][ch] = 0;
              end
            end else begin
              if (m_run[u][ch] > 0 && m_gl[u][ch] < 255) m_gl[u][ch]++;
              m_run[u][ch] = 0;
            end
          end
        end
        if (c) for (int ch = 0; ch < 2; ch++) m_gl[u][ch] = 0;
        m_d2[u] = m_d1[u];
        m_d1[u] = d;
      end
    end
  endtask

  task automatic step(input logic r, input logic [1:0] d, input logic c);
    @(negedge clk);
    rst = r; din = d; clr = c;
    @(posedge clk);
    model_step(r, d, c);
    #1;
    chk("dout_p1", 16'(bus1.dout), 16'(m_out[0]));
    chk("rise_p1", 16'(bus1.rise), 16'(m_rise[0]));
    chk("fall_p1", 16'(bus1.fall), 16'(m_fall[0]));
    chk("dout_p3", 16'(bus3.dout), 16'(m_out[1]));
    chk("rise_p3", 16'(bus3.rise), 16'(m_rise[1]));
    chk("fall_p3", 16'(bus3.fall), 16'(m_fall[1]));
`ifdef FILTER_GLITCH_CNT_EN
    chk("gcnt_p1", bus1.glitch_cnt, {8'(m_gl[0][1]), 8'(m_gl[0][0])});
    chk("gcnt_p3", bus3.glitch_cnt, {8'(m_gl[1][1]), 8'(m_gl[1][0])});
`endif
  endtask

  task automatic run(input int n, input logic r, input logic [1:0] d);
    for (int k = 0; k < n; k++) step(r, d, 1'b0);
  endtask

  initial begin
    int fall_edge;
    logic [1:0] rd;
    // 1: reset with lines low, then release
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 2'b00, 1'b0);
      chk("t1_rst_dout", 16'(bus1.dout), 16'h3);
      chk("t1_rst_strb", 16'({bus1.rise, bus1.fall}), 16'h0);
    end
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 2'b00, 1'b0);
      chk("t1_fall", 16'(bus1.fall), (k == 6) ? 16'h3 : 16'h0);
    end
    chk("t1_dout", 16'(bus1.dout), 16'h0);
    run(8, 1'b0, 2'b11);
    chk("t1_back_high", 16'(bus1.dout), 16'h3);

    // 2: 3-sample low pulse on ch0 is rejected
    for (int k = 0; k < 11; k++) begin
      step(1'b0, (k < 3) ? 2'b10 : 2'b11, 1'b0);
      chk("t2_dout0", 16'(bus1.dout[0]), 16'h1);
      chk("t2_nofall", 16'(bus1.fall), 16'h0);
    end
`ifdef FILTER_GLITCH_CNT_EN
    chk("t2_gcnt", bus1.glitch_cnt, 16'h0001);
`endif

    // 3: held low then held high on ch0
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 2'b10, 1'b0);
      chk("t3_fall0", 16'(bus1.fall), (k == 6) ? 16'h1 : 16'h0);
    end
    chk("t3_dout_low", 16'(bus1.dout), 16'h2);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 2'b11, 1'b0);
      chk("t3_rise0", 16'(bus1.rise), (k == 6) ? 16'h1 : 16'h0);
    end
    chk("t3_dout_high", 16'(bus1.dout), 16'h3);

    // 4: PRESCALE=3 lane, ch1 held low after a fresh reset
    step(1'b1, 2'b11, 1'b0);
    fall_edge = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 2'b01, 1'b0);
      if (bus3.fall[1] && fall_edge == 0) fall_edge = k;
    end
    chk("t4_fall_edge_lo", 16'(fall_edge >= 12), 16'h1);
    chk("t4_fall_edge_hi", 16'(fall_edge <= 14), 16'h1);
    run(20, 1'b0, 2'b11);
    run(2, 1'b0, 2'b01);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 2'b11, 1'b0);
      chk("t4_pulse_p3", 16'(bus3.dout[1]), 16'h1);
    end

    // 5: reset mid-run discards the partial count
    run(3, 1'b0, 2'b10);
    step(1'b1, 2'b10, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 2'b10, 1'b0);
      chk("t5_fall0", 16'(bus1.fall), (k == 6) ? 16'h1 : 16'h0);
    end
    run(10, 1'b0, 2'b11);

`ifdef FILTER_GLITCH_CNT_EN
    // 6: saturation at 255, then clear colliding with a glitch event
    step(1'b1, 2'b11, 1'b0);
    for (int g = 0; g < 300; g++) begin
      run(2, 1'b0, 2'b01);
      run(4, 1'b0, 2'b11);
    end
    chk("t6_sat", 16'(bus1.glitch_cnt[15:8]), 16'd255);
    run(2, 1'b0, 2'b01);
    run(2, 1'b0, 2'b11);
    step(1'b0, 2'b11, 1'b1);
    chk("t6_clr", 16'(bus1.glitch_cnt[15:8]), 16'd0);
    run(4, 1'b0, 2'b11);
`endif

    // random segments: each channel held for a random span, occasional reset/clear
    for (int s = 0; s < 400; s++) begin
      int len = $urandom_range(1, 7);
      logic r = ($urandom_range(0, 63) == 0);
      rd = 2'($urandom);
      for (int k = 0; k < len; k++)
        step(r && (k == 0), rd, ($urandom_range(0, 31) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
